// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction-fetch controller.
package ifetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] PC_RESET_DEF  = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP_DEF   = 32'd4;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  // 65-bit IF/ID entry
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pcplus4;
    logic            valid;
  } ifid_entry_t;

  // Bubble entry: NOP with no associated PC and Valid=0
  function automatic ifid_entry_t bubble_entry(input logic [XLEN-1:0] nop);
    ifid_entry_t e;
    e.instr   = nop;
    e.pcplus4 = '0;
    e.valid   = 1'b0;
    return e;
  endfunction

endpackage

// File: rtl/ifetch_ctrl_if_id_reg.sv
// IF/ID-style register with load / hold / bubble controls; also used as the hold buffer.
module if_id_reg
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        bubble_i,
  input  ifid_entry_t d_i,
  output ifid_entry_t q_o
);

  ifid_entry_t q_q;

  // Reset and bubble both load the NOP entry; otherwise load or hold
  always_ff @(posedge clk_i) begin
    if (rst_i || bubble_i) begin
      q_q <= bubble_entry(NOP_INSTR);
    end else if (load_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch controller: PC register, instruction-memory handshake and IF/ID register.
// Optional build macro IFETCH_PERF_EN adds saturating performance counters.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_RESET  = PC_RESET_DEF,
  parameter logic [XLEN-1:0] PC_STEP   = PC_STEP_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            PC_Stall,
  input  logic            IFID_Stall,
  input  logic            IFID_Flush,
  input  logic            Redirect,
  input  logic [XLEN-1:0] RedirectTarget,
  output logic            IMem_Req,
  output logic [XLEN-1:0] IMem_Addr,
  input  logic            IMem_Ready,
  input  logic [XLEN-1:0] IMem_Data,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] IFID_Instr,
  output logic [XLEN-1:0] IFID_PCPlus4,
`ifdef IFETCH_PERF_EN
  output logic [XLEN-1:0] PerfFetched,
  output logic [XLEN-1:0] PerfDiscarded,
  output logic [XLEN-1:0] PerfStallCycles,
`endif
  output logic            IFID_Valid
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            req_q;
  logic [XLEN-1:0] pc_plus_step;

  logic            ifid_load, ifid_bubble;
  logic            buf_load, buf_bubble;
  ifid_entry_t     fetch_entry, ifid_d, ifid_q, buf_q;

  assign pc_plus_step = pc_q + PC_STEP;

  always_comb begin
    fetch_entry.instr   = IMem_Data;
    fetch_entry.pcplus4 = pc_plus_step;
    fetch_entry.valid   = 1'b1;
  end

  // State, PC, pending target and request registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_FETCH;
      pc_q    <= PC_RESET;
      pend_q  <= '0;
      req_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      req_q   <= (state_d != ST_HOLD);
    end
  end

  // Next-state, PC update and IF/ID / hold-buffer control
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    buf_load    = 1'b0;
    buf_bubble  = 1'b0;
    ifid_d      = fetch_entry;

    unique case (state_q)
      ST_FETCH: begin
        if (IMem_Ready) begin
          if (Redirect) begin
            pc_d        = RedirectTarget;
            ifid_bubble = 1'b1;
          end else if (PC_Stall) begin
            // response dropped; PC refetched next cycle
            ifid_bubble = IFID_Flush || !IFID_Stall;
          end else begin
            pc_d = pc_plus_step;
            if (IFID_Flush) begin
              ifid_bubble = 1'b1;
            end else if (IFID_Stall) begin
              buf_load = 1'b1;
              state_d  = ST_HOLD;
            end else begin
              ifid_load = 1'b1;
            end
          end
        end else if (Redirect) begin
          pend_d      = RedirectTarget;
          ifid_bubble = 1'b1;
          state_d     = ST_DRAIN;
        end else begin
          ifid_bubble = IFID_Flush || !IFID_Stall;
        end
      end

      ST_DRAIN: begin
        ifid_bubble = 1'b1;
        if (Redirect) begin
          pend_d = RedirectTarget;
        end
        if (IMem_Ready) begin
          pc_d    = Redirect ? RedirectTarget : pend_q;
          state_d = ST_FETCH;
        end
      end

      ST_HOLD: begin
        ifid_d = buf_q;
        if (Redirect) begin
          buf_bubble  = 1'b1;
          pc_d        = RedirectTarget;
          ifid_bubble = 1'b1;
          state_d     = ST_FETCH;
        end else if (IFID_Flush) begin
          ifid_bubble = 1'b1;
        end else if (!IFID_Stall) begin
          ifid_load = 1'b1;
          state_d   = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_ifid (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .load_i   (ifid_load),
    .bubble_i (ifid_bubble),
    .d_i      (ifid_d),
    .q_o      (ifid_q)
  );

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_hold_buf (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .load_i   (buf_load),
    .bubble_i (buf_bubble),
    .d_i      (fetch_entry),
    .q_o      (buf_q)
  );

  assign IMem_Req     = req_q;
  assign IMem_Addr    = pc_q;
  assign PC           = pc_q;
  assign IFID_Instr   = ifid_q.instr;
  assign IFID_PCPlus4 = ifid_q.pcplus4;
  assign IFID_Valid   = ifid_q.valid;

`ifdef IFETCH_PERF_EN
  logic [XLEN-1:0] perf_fetched_q, perf_discarded_q, perf_stall_q;
  logic            discard_c;

  // A returned word is dropped in DRAIN, or in FETCH when any hazard overrides delivery
  assign discard_c = IMem_Ready &&
                     ((state_q == ST_DRAIN) ||
                      ((state_q == ST_FETCH) && (Redirect || PC_Stall || IFID_Flush)));

  // Saturating event counters
  always_ff @(posedge Clk) begin
    if (Reset) begin
      perf_fetched_q   <= '0;
      perf_discarded_q <= '0;
      perf_stall_q     <= '0;
    end else begin
      if (ifid_load && (perf_fetched_q != '1)) perf_fetched_q <= perf_fetched_q + XLEN'(1);
      if (discard_c && (perf_discarded_q != '1)) perf_discarded_q <= perf_discarded_q + XLEN'(1);
      if (IFID_Stall && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + XLEN'(1);
    end
  end

  assign PerfFetched     = perf_fetched_q;
  assign PerfDiscarded   = perf_discarded_q;
  assign PerfStallCycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed vector table plus randomized run vs. reference model.
module tb_ifetch_ctrl;

  logic        Clk = 1'b0;
  logic        Reset, PC_Stall, IFID_Stall, IFID_Flush, Redirect, IMem_Ready;
  logic [31:0] RedirectTarget, IMem_Data, IMem_Addr, PC, IFID_Instr, IFID_PCPlus4;
  logic        IMem_Req, IFID_Valid;
`ifdef IFETCH_PERF_EN
  logic [31:0] PerfFetched, PerfDiscarded, PerfStallCycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  // Memory contents are a fixed scramble of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0101_0101) ^ 32'hC0DE_1357;
  endfunction

  assign IMem_Data = mem_word(IMem_Addr);

  ifetch_ctrl dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .PC_Stall       (PC_Stall),
    .IFID_Stall     (IFID_Stall),
    .IFID_Flush     (IFID_Flush),
    .Redirect       (Redirect),
    .RedirectTarget (RedirectTarget),
    .IMem_Req       (IMem_Req),
    .IMem_Addr      (IMem_Addr),
    .IMem_Ready     (IMem_Ready),
    .IMem_Data      (IMem_Data),
    .PC             (PC),
    .IFID_Instr     (IFID_Instr),
    .IFID_PCPlus4   (IFID_PCPlus4),
`ifdef IFETCH_PERF_EN
    .PerfFetched    (PerfFetched),
    .PerfDiscarded  (PerfDiscarded),
    .PerfStallCycles(PerfStallCycles),
`endif
    .IFID_Valid     (IFID_Valid)
  );

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        rst, pcs, ifs, fl, rd;
    logic [31:0] tgt;
    logic        rdy;
    logic [31:0] e_pc;
    logic        e_req, e_v;
    logic [31:0] e_pp4;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic pcs, input logic ifs, input logic fl,
                              input logic rd, input logic [31:0] tgt, input logic rdy,
                              input logic [31:0] e_pc, input logic e_req, input logic e_v,
                              input logic [31:0] e_pp4);
    vec_t v;
    v.rst = rst; v.pcs = pcs; v.ifs = ifs; v.fl = fl; v.rd = rd; v.tgt = tgt; v.rdy = rdy;
    v.e_pc = e_pc; v.e_req = e_req; v.e_v = e_v; v.e_pp4 = e_pp4;
    return v;
  endfunction

  localparam int NVEC = 22;
  vec_t tbl [NVEC];

  // ---------------- reference model ----------------
  localparam int M_RUN = 0, M_DRAIN = 1, M_HOLD = 2;
  int          m_mode;
  logic [31:0] m_pc, m_pend, m_instr, m_pp4, m_binstr, m_bpp4;
  logic        m_valid;

  task automatic m_bubble();
    m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
  endtask

  task automatic m_deliver(input logic [31:0] w, input logic [31:0] p4);
    m_instr = w; m_pp4 = p4; m_valid = 1'b1;
  endtask

  // One clock of the fetch rules applied to the current inputs
  task automatic model_step();
    logic [31:0] w, nxt;
    if (Reset) begin
      m_pc = 32'h0; m_mode = M_RUN; m_pend = 32'h0; m_binstr = 32'h0; m_bpp4 = 32'h0;
      m_bubble();
    end else if (m_mode == M_HOLD) begin
      if (Redirect) begin
        m_pc = RedirectTarget; m_bubble(); m_mode = M_RUN;
      end else if (IFID_Flush) begin
        m_bubble();
      end else if (!IFID_Stall) begin
        m_deliver(m_binstr, m_bpp4); m_mode = M_RUN;
      end
    end else if (m_mode == M_DRAIN) begin
      m_bubble();
      if (IMem_Ready) begin
        m_pc = Redirect ? RedirectTarget : m_pend;
        m_mode = M_RUN;
      end else if (Redirect) begin
        m_pend = RedirectTarget;
      end
    end else if (!IMem_Ready) begin
      if (Redirect) begin
        m_pend = RedirectTarget; m_bubble(); m_mode = M_DRAIN;
      end else if (IFID_Flush || !IFID_Stall) begin
        m_bubble();
      end
    end else if (Redirect) begin
      m_pc = RedirectTarget; m_bubble();
    end else if (PC_Stall) begin
      if (IFID_Flush || !IFID_Stall) m_bubble();
    end else begin
      w = mem_word(m_pc);
      nxt = m_pc + 32'd4;
      m_pc = nxt;
      if (IFID_Flush) m_bubble();
      else if (IFID_Stall) begin
        m_binstr = w; m_bpp4 = nxt; m_mode = M_HOLD;
      end else m_deliver(w, nxt);
    end
  endtask

  initial begin
    // reset, zero-wait stream
    tbl[0]  = mk(1,0,0,0,0,32'h0,1, 32'h00,1,0,32'h00);
    tbl[1]  = mk(0,0,0,0,0,32'h0,1, 32'h04,1,1,32'h04);
    tbl[2]  = mk(0,0,0,0,0,32'h0,1, 32'h08,1,1,32'h08);
    // PC_Stall + IFID_Stall at PC=8 for two cycles
    tbl[3]  = mk(0,1,1,0,0,32'h0,1, 32'h08,1,1,32'h08);
    tbl[4]  = mk(0,1,1,0,0,32'h0,1, 32'h08,1,1,32'h08);
    tbl[5]  = mk(0,0,0,0,0,32'h0,1, 32'h0C,1,1,32'h0C);
    tbl[6]  = mk(0,0,0,0,0,32'h0,1, 32'h10,1,1,32'h10);
    // redirect to 0x40 while not ready at 0x10 -> drain
    tbl[7]  = mk(0,0,0,0,1,32'h40,0, 32'h10,1,0,32'h00);
    tbl[8]  = mk(0,0,0,0,0,32'h0,0, 32'h10,1,0,32'h00);
    tbl[9]  = mk(0,0,0,0,0,32'h0,1, 32'h40,1,0,32'h00);
    tbl[10] = mk(0,0,0,0,0,32'h0,1, 32'h44,1,1,32'h44);
    // redirect to 0x20, then IFID_Stall on the returned word -> hold
    tbl[11] = mk(0,0,0,0,1,32'h20,1, 32'h20,1,0,32'h00);
    tbl[12] = mk(0,0,1,0,0,32'h0,1, 32'h24,0,0,32'h00);
    tbl[13] = mk(0,0,1,0,0,32'h0,0, 32'h24,0,0,32'h00);
    tbl[14] = mk(0,0,0,0,0,32'h0,0, 32'h24,1,1,32'h24);
    tbl[15] = mk(0,0,0,0,0,32'h0,1, 32'h28,1,1,32'h28);
    // reset while draining with a response pending
    tbl[16] = mk(0,0,0,0,1,32'h80,0, 32'h28,1,0,32'h00);
    tbl[17] = mk(1,0,0,0,0,32'h0,1, 32'h00,1,0,32'h00);
    tbl[18] = mk(0,0,0,0,0,32'h0,0, 32'h00,1,0,32'h00);
    tbl[19] = mk(0,0,0,0,0,32'h0,1, 32'h04,1,1,32'h04);
    // wrap at the top of the address space
    tbl[20] = mk(0,0,0,0,1,32'hFFFF_FFFC,1, 32'hFFFF_FFFC,1,0,32'h00);
    tbl[21] = mk(0,0,0,0,0,32'h0,1, 32'h00,1,1,32'h00);

    for (int i = 0; i < NVEC; i++) begin
      logic [31:0] e_instr;
      Reset = tbl[i].rst; PC_Stall = tbl[i].pcs; IFID_Stall = tbl[i].ifs;
      IFID_Flush = tbl[i].fl; Redirect = tbl[i].rd; RedirectTarget = tbl[i].tgt;
      IMem_Ready = tbl[i].rdy;
      @(posedge Clk); #1;
      e_instr = tbl[i].e_v ? mem_word(tbl[i].e_pp4 - 32'd4) : 32'h0;
      check("vec_pc",    i, PC,                 tbl[i].e_pc);
      check("vec_addr",  i, IMem_Addr,          tbl[i].e_pc);
      check("vec_req",   i, 32'(IMem_Req),      32'(tbl[i].e_req));
      check("vec_valid", i, 32'(IFID_Valid),    32'(tbl[i].e_v));
      check("vec_pp4",   i, IFID_PCPlus4,       tbl[i].e_pp4);
      check("vec_instr", i, IFID_Instr,         e_instr);
    end

    // ---------------- randomized run vs. model ----------------
    for (int c = 0; c < 3000; c++) begin
      Reset      = (c == 0) || ($urandom_range(0, 99) == 0);
      PC_Stall   = ($urandom_range(0, 7) == 0);
      IFID_Stall = ($urandom_range(0, 4) == 0);
      IFID_Flush = ($urandom_range(0, 9) == 0);
      Redirect   = ($urandom_range(0, 11) == 0);
      IMem_Ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 5) == 0) RedirectTarget = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else RedirectTarget = $urandom & 32'h0000_0FFF;
      model_step();
      @(posedge Clk); #1;
      check("rnd_pc",    c, PC,              m_pc);
      check("rnd_addr",  c, IMem_Addr,       m_pc);
      check("rnd_req",   c, 32'(IMem_Req),   32'(m_mode != M_HOLD));
      check("rnd_valid", c, 32'(IFID_Valid), 32'(m_valid));
      check("rnd_pp4",   c, IFID_PCPlus4,    m_pp4);
      check("rnd_instr", c, IFID_Instr,      m_instr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Fetch-side consumer of the hazard detector's PC_Stall / IFID_Stall / IFID_Flush outputs.
- Owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- Applies stalls, bubbles and MEM-stage redirects (taken branch, jump, jr) cycle-accurately.
- Sits between instruction memory and the ID stage of the 5-stage MIPS pipeline.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, PC increment per delivered instruction.
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID as a bubble.

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high reset
- PC_Stall  in  1  hold PC; any instruction returned this cycle is discarded
- IFID_Stall  in  1  hold IF/ID contents
- IFID_Flush  in  1  load bubble into IF/ID
- Redirect  in  1  MEM-stage taken branch or jump
- RedirectTarget  in  32  new PC, valid with Redirect
- IMem_Req  out  1  fetch request
- IMem_Addr  out  32  fetch address; always equals PC while IMem_Req=1
- IMem_Ready  in  1  data valid and request complete this cycle; zero-wait allowed
- IMem_Data  in  32  instruction word
- PC  out  32  current fetch PC
- IFID_Instr  out  32  ID-stage instruction
- IFID_PCPlus4  out  32  PC+PC_STEP of the ID-stage instruction
- IFID_Valid  out  1  0 = bubble

Behaviour:
- Reset (synchronous, active-high; wins over all inputs, including mid-request): PC=PC_RESET, IFID_Instr=NOP_INSTR, IFID_PCPlus4=0, IFID_Valid=0, hold buffer cleared, state=FETCH. Any outstanding response is ignored.
- States: FETCH, DRAIN, HOLD.
- Handshake: IMem_Req=1 in FETCH and DRAIN, 0 in HOLD. IMem_Addr stays stable until the cycle IMem_Ready=1.
- Priority within a cycle: Reset > Redirect > PC_Stall > IFID_Flush > IFID_Stall.
- FETCH with IMem_Ready=1:
  - Redirect: PC<=RedirectTarget; data discarded; IF/ID<=bubble.
  - Else PC_Stall: PC unchanged (refetched next cycle); data discarded; IF/ID<=bubble if IFID_Flush, held if IFID_Stall.
  - Else: PC<=PC+PC_STEP.
    - IFID_Flush: data discarded; IF/ID<=bubble.
    - IFID_Stall: data and PC+PC_STEP go to the hold buffer; IF/ID held; go to HOLD.
    - Otherwise: IF/ID<={IMem_Data, PC+PC_STEP, Valid=1}.
- FETCH with IMem_Ready=0:
  - Redirect: latch the target into pending_pc; IF/ID<=bubble; go to DRAIN.
  - Else: IF/ID held if IFID_Stall and not IFID_Flush, otherwise bubble.
- DRAIN:
  - Request continues on the old address; a further Redirect overwrites pending_pc. IF/ID<=bubble every cycle.
  - On IMem_Ready: data discarded; PC<=pending_pc (or RedirectTarget if Redirect is asserted the same cycle); go to FETCH.
- HOLD:
  - Redirect: buffer dropped; PC<=RedirectTarget; IF/ID<=bubble; go to FETCH.
  - Else IFID_Flush: IF/ID<=bubble; buffer retained; stay in HOLD.
  - Else IFID_Stall: hold; stay in HOLD.
  - Else: IF/ID<=buffer (Valid=1); go to FETCH.
- Arithmetic: PC and PC+4 are 32-bit and wrap modulo 2^32 (32'hFFFF_FFFC -> 0). Low 2 bits of RedirectTarget are passed through unmodified.
- Latency: zero-wait memory with no hazards gives one instruction per cycle. Instruction fetched in cycle N appears on the IF/ID outputs in cycle N+1.

Optional Feature:
- Macro IFETCH_PERF_EN.
- Defined: adds three 32-bit saturating output counters, cleared on Reset:
  - PerfFetched: deliveries into IF/ID with Valid=1.
  - PerfDiscarded: responses dropped because of Redirect, PC_Stall, IFID_Flush or DRAIN.
  - PerfStallCycles: cycles with IFID_Stall=1.
- Undefined: the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package ifetch_pkg: state encoding (FETCH/DRAIN/HOLD), NOP_INSTR default, PC_STEP default, and the 65-bit IF/ID entry type {instr, pcplus4, valid}.
- One sub-module, if_id_reg: IF/ID register with load, hold and bubble controls. Reused by the hold buffer.

Test Plan:
- Reset, then IMem_Ready tied 1 with no hazards -> IMem_Addr 0,4,8,C on consecutive cycles; IFID_Instr matches the memory words one cycle later with IFID_Valid=1.
- PC_Stall=1 and IFID_Stall=1 for 2 cycles at PC=8 -> IMem_Addr stays 8; IF/ID holds the word from 4; after release, the word from 8 arrives once with no duplicate.
- Redirect=1 with target 0x40 while IMem_Ready=0 at PC=0x10 -> DRAIN; IMem_Addr held at 0x10 until Ready; next request to 0x40; IF/ID shows bubbles throughout.
- IFID_Stall=1 with PC_Stall=0 on a returned word at 0x20 -> HOLD, IMem_Req=0, PC=0x24; on release IF/ID gets the 0x20 word with PCPlus4=0x24.
- Reset asserted in DRAIN with Ready pending -> next cycle PC=0, IFID_Valid=0, state FETCH; the late response is ignored.
- PC=32'hFFFF_FFFC fetch -> PC wraps to 0; IFID_PCPlus4=0.
